// File: rtl/dot_prod_acc_pip.sv
// Pipelined complex dot-product accumulator.
// Each accepted x/y pair is multiplied as a complex product, with optional
// conjugation of y. The products are summed over LENGTH pairs. The finished
// sum is held in an output register with a valid/ready handshake.
//
// Handshake semantics:
//   Input side:  a pair transfers on a rising edge when m_axis_x_tvalid,
//                m_axis_y_tvalid and s_axis_xy_tready are all 1.
//   Output side: a result transfers on a rising edge when
//                s_axis_product_tvalid and m_axis_product_tready are both 1.
//                While a result waits, i/q do not change.
//   A pending result that is not taken (stall) freezes the whole pipeline.
//   It also drops s_axis_xy_tready, so no pair can be lost or overtaken.
//
// Pipeline: input capture -> partial products -> complex product -> accumulate.
// The final pair of a vector reaches the output register 3 edges after the
// edge that accepts it.
module dot_prod_acc_pip #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 8,
    parameter int LENGTH = 4,
    localparam int SUM_BITS = X_BITS + Y_BITS + 1 + $clog2(LENGTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_axis_x_tvalid,
    input  logic signed [X_BITS-1:0]   xi,
    input  logic signed [X_BITS-1:0]   xq,
    input  logic                       m_axis_y_tvalid,
    input  logic signed [Y_BITS-1:0]   yi,
    input  logic signed [Y_BITS-1:0]   yq,
    input  logic                       conj,
    output logic                       s_axis_xy_tready,
    input  logic                       m_axis_product_tready,
    output logic                       s_axis_product_tvalid,
    output logic signed [SUM_BITS-1:0] i,
    output logic signed [SUM_BITS-1:0] q
);

    localparam int CNT_BITS = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LENGTH - 1);

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic stall;
    logic accept;
    logic prod_valid_q, prod_valid_d;

    // Reset forces ready high, and accept is gated so nothing enters during reset.
    assign stall            = prod_valid_q & ~m_axis_product_tready & ~reset;
    assign s_axis_xy_tready = ~stall;
    assign accept           = m_axis_x_tvalid & m_axis_y_tvalid & ~stall & ~reset;

    // ------------------------------------------------------------------
    // Sample counter: position of the next accepted pair within its vector
    // ------------------------------------------------------------------
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // Advance on every accept and wrap after the LENGTH-th pair.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // ------------------------------------------------------------------
    // Stage 0: capture of the accepted pair
    // ------------------------------------------------------------------
    logic                     s0_vld_q,  s0_vld_d;
    logic                     s0_last_q, s0_last_d;
    logic                     s0_conj_q, s0_conj_d;
    logic signed [X_BITS-1:0] s0_xi_q,   s0_xi_d;
    logic signed [X_BITS-1:0] s0_xq_q,   s0_xq_d;
    logic signed [Y_BITS-1:0] s0_yi_q,   s0_yi_d;
    logic signed [Y_BITS-1:0] s0_yq_q,   s0_yq_d;

    // Load the pair on accept; otherwise insert a bubble unless stalled.
    always_comb begin
        s0_vld_d  = s0_vld_q;
        s0_last_d = s0_last_q;
        s0_conj_d = s0_conj_q;
        s0_xi_d   = s0_xi_q;
        s0_xq_d   = s0_xq_q;
        s0_yi_d   = s0_yi_q;
        s0_yq_d   = s0_yq_q;
        if (!stall) begin
            s0_vld_d  = accept;
            s0_last_d = accept & cnt_last;
            if (accept) begin
                s0_conj_d = conj;
                s0_xi_d   = xi;
                s0_xq_d   = xq;
                s0_yi_d   = yi;
                s0_yq_d   = yq;
            end
        end
    end

    // Stage 0 registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_vld_q  <= 1'b0;
            s0_last_q <= 1'b0;
            s0_conj_q <= 1'b0;
            s0_xi_q   <= '0;
            s0_xq_q   <= '0;
            s0_yi_q   <= '0;
            s0_yq_q   <= '0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_last_q <= s0_last_d;
            s0_conj_q <= s0_conj_d;
            s0_xi_q   <= s0_xi_d;
            s0_xq_q   <= s0_xq_d;
            s0_yi_q   <= s0_yi_d;
            s0_yq_q   <= s0_yq_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: four partial products, operands sign-extended to SUM_BITS
    // ------------------------------------------------------------------
    logic                       s1_vld_q,  s1_vld_d;
    logic                       s1_last_q, s1_last_d;
    logic                       s1_conj_q, s1_conj_d;
    logic signed [SUM_BITS-1:0] s1_ii_q,   s1_ii_d;
    logic signed [SUM_BITS-1:0] s1_qq_q,   s1_qq_d;
    logic signed [SUM_BITS-1:0] s1_iq_q,   s1_iq_d;
    logic signed [SUM_BITS-1:0] s1_qi_q,   s1_qi_d;

    // Form xi*yi, xq*yq, xi*yq and xq*yi at full precision.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s1_conj_d = s1_conj_q;
        s1_ii_d   = s1_ii_q;
        s1_qq_d   = s1_qq_q;
        s1_iq_d   = s1_iq_q;
        s1_qi_d   = s1_qi_q;
        if (!stall) begin
            s1_vld_d  = s0_vld_q;
            s1_last_d = s0_last_q;
            s1_conj_d = s0_conj_q;
            s1_ii_d   = SUM_BITS'(s0_xi_q) * SUM_BITS'(s0_yi_q);
            s1_qq_d   = SUM_BITS'(s0_xq_q) * SUM_BITS'(s0_yq_q);
            s1_iq_d   = SUM_BITS'(s0_xi_q) * SUM_BITS'(s0_yq_q);
            s1_qi_d   = SUM_BITS'(s0_xq_q) * SUM_BITS'(s0_yi_q);
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_conj_q <= 1'b0;
            s1_ii_q   <= '0;
            s1_qq_q   <= '0;
            s1_iq_q   <= '0;
            s1_qi_q   <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_conj_q <= s1_conj_d;
            s1_ii_q   <= s1_ii_d;
            s1_qq_q   <= s1_qq_d;
            s1_iq_q   <= s1_iq_d;
            s1_qi_q   <= s1_qi_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: complex product real/imag
    // ------------------------------------------------------------------
    logic                       s2_vld_q,  s2_vld_d;
    logic                       s2_last_q, s2_last_d;
    logic signed [SUM_BITS-1:0] s2_re_q,   s2_re_d;
    logic signed [SUM_BITS-1:0] s2_im_q,   s2_im_d;

    // Conjugating y flips the sign of every yq term.
    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_last_d = s2_last_q;
        s2_re_d   = s2_re_q;
        s2_im_d   = s2_im_q;
        if (!stall) begin
            s2_vld_d  = s1_vld_q;
            s2_last_d = s1_last_q;
            if (s1_conj_q) begin
                s2_re_d = s1_ii_q + s1_qq_q;
                s2_im_d = s1_qi_q - s1_iq_q;
            end else begin
                s2_re_d = s1_ii_q - s1_qq_q;
                s2_im_d = s1_iq_q + s1_qi_q;
            end
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_re_q   <= '0;
            s2_im_q   <= '0;
        end else begin
            s2_vld_q  <= s2_vld_d;
            s2_last_q <= s2_last_d;
            s2_re_q   <= s2_re_d;
            s2_im_q   <= s2_im_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: accumulate and result register
    // ------------------------------------------------------------------
    logic signed [SUM_BITS-1:0] acc_i_q, acc_i_d;
    logic signed [SUM_BITS-1:0] acc_q_q, acc_q_d;
    logic signed [SUM_BITS-1:0] res_i_q, res_i_d;
    logic signed [SUM_BITS-1:0] res_q_q, res_q_d;
    logic                       res_write;

    assign res_write = ~stall & s2_vld_q & s2_last_q;

    // The last pair of a vector publishes the full sum and restarts the accumulator at zero.
    always_comb begin
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        if (!stall && s2_vld_q) begin
            if (s2_last_q) begin
                acc_i_d = '0;
                acc_q_d = '0;
            end else begin
                acc_i_d = acc_i_q + s2_re_q;
                acc_q_d = acc_q_q + s2_im_q;
            end
        end
    end

    // A new result may replace one being consumed on the same edge.
    always_comb begin
        res_i_d      = res_i_q;
        res_q_d      = res_q_q;
        prod_valid_d = prod_valid_q;
        if (res_write) begin
            res_i_d      = acc_i_q + s2_re_q;
            res_q_d      = acc_q_q + s2_im_q;
            prod_valid_d = 1'b1;
        end else if (m_axis_product_tready) begin
            prod_valid_d = 1'b0;
        end
    end

    // Accumulator and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            res_i_q      <= '0;
            res_q_q      <= '0;
            prod_valid_q <= 1'b0;
        end else begin
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            res_i_q      <= res_i_d;
            res_q_q      <= res_q_d;
            prod_valid_q <= prod_valid_d;
        end
    end

    assign s_axis_product_tvalid = prod_valid_q;
    assign i                     = res_i_q;
    assign q                     = res_q_q;

endmodule

// File: doc/dot_prod_acc_pip.md
DOT_PROD_ACC_PIP -- requirements
Module: dot_prod_acc_pip

Interface
REQ-001 Parameter X_BITS, default 8: signed width of xi and xq.
REQ-002 Parameter Y_BITS, default 8: signed width of yi and yq.
REQ-003 Parameter LENGTH, default 4: number of sample pairs per dot product; legal range 1..4096.
REQ-004 Derived SUM_BITS SHALL equal X_BITS+Y_BITS+1+clog2(LENGTH), with clog2(1)=0.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 m_axis_x_tvalid  input  1  xi/xq valid.
REQ-008 xi, xq  input  X_BITS each  signed real/imag of x sample.
REQ-009 m_axis_y_tvalid  input  1  yi/yq valid.
REQ-010 yi, yq  input  Y_BITS each  signed real/imag of y sample.
REQ-011 conj  input  1  1 = use conjugate of y for this pair; sampled with the pair.
REQ-012 s_axis_xy_tready  output  1  block accepts an x/y pair this cycle.
REQ-013 m_axis_product_tready  input  1  downstream accepts result.
REQ-014 s_axis_product_tvalid  output  1  result register holds an unconsumed result.
REQ-015 i, q  output  SUM_BITS each  signed real/imag of the dot product.

Function
REQ-016 A pair SHALL be accepted on a rising edge only when m_axis_x_tvalid, m_axis_y_tvalid and s_axis_xy_tready are all 1; a single valid SHALL accept nothing and leave all state unchanged.
REQ-017 Per accepted pair, the product SHALL be (xi+j*xq)*(yi+j*yq) when conj=0, and (xi+j*xq)*(yi-j*yq) when conj=1.
REQ-018 Arithmetic SHALL be signed two's complement at full precision, operands sign-extended to SUM_BITS, with no rounding, saturation or truncation.
REQ-019 Pipeline: stage 1 registers the four partial products; stage 2 registers the product real/imag; stage 3 adds into the accumulator.
REQ-020 A sample counter SHALL count accepted pairs 0..LENGTH-1 and wrap to 0 after the LENGTH-th.
REQ-021 When the LENGTH-th pair of a vector reaches stage 3, the complete sum SHALL be written into i/q, s_axis_product_tvalid SHALL be set, and the accumulator SHALL be cleared in the same cycle so that the next vector starts from 0.
REQ-022 Without stall, s_axis_product_tvalid SHALL rise 3 cycles after the edge that accepts the final pair.
REQ-023 Stall SHALL be defined as s_axis_product_tvalid=1 and m_axis_product_tready=0; during stall every pipeline stage, the counter and the accumulator SHALL hold their values, and s_axis_xy_tready SHALL be 0.
REQ-024 s_axis_xy_tready SHALL equal NOT stall, combinationally.
REQ-025 While s_axis_product_tvalid=1, i and q SHALL remain stable until a rising edge with m_axis_product_tready=1.
REQ-026 If a result is consumed on an edge where a new result is also written, the new result SHALL load and s_axis_product_tvalid SHALL stay 1.
REQ-027 If a result is consumed and no new result is written, s_axis_product_tvalid SHALL clear.
REQ-028 Pairs from consecutive vectors SHALL stream back-to-back with no bubble when there is no stall.
REQ-029 With LENGTH=1, every accepted pair SHALL produce one result.

Reset
REQ-030 While reset=1 on a rising edge, the block SHALL clear the pipeline stage valids, partial products, accumulator and counter to 0.
REQ-031 While reset=1 on a rising edge, the block SHALL set s_axis_product_tvalid=0 and i=q=0.
REQ-032 Reset SHALL take priority over accept, stall and result writes.
REQ-033 A partial vector in progress at reset SHALL be discarded.
REQ-034 During reset, s_axis_xy_tready SHALL be 1, and pairs presented SHALL not be accepted.

Verification (LENGTH=4, X_BITS=Y_BITS=8, SUM_BITS=19)
REQ-035 Four pairs x=(1,2), y=(3,4), conj=0 -> i=-20, q=40, tvalid rises 3 cycles after the 4th accept.
REQ-036 Same stimulus with conj=1 -> i=44, q=8.
REQ-037 Four pairs x=(-128,-128), y=(-128,-128), conj=0 -> i=0, q=131072, with no overflow.
REQ-038 Hold m_axis_product_tready=0 after the first result and stream a second vector: s_axis_xy_tready drops to 0, i/q stay stable, and no pair is lost; raise tready for 1 cycle -> the second result appears correctly.
REQ-039 Toggle m_axis_x_tvalid alone for 5 cycles with m_axis_y_tvalid=0 -> no accept, no result; then a normal vector produces the correct sum.
REQ-040 Assert reset after 2 accepts of x=(5,0), y=(5,0), then send 4 pairs x=(1,0), y=(1,0) -> exactly one result, i=4, q=0.
